syn_pcm_mcbuf: RTL and testbench
================================

SYN_PCM_MCBUF -- requirements
Module: syn_pcm_mcbuf

Interface
REQ-001 Parameter DATA_W, default 32, bits per channel sample.
REQ-002 Parameter ADDR_W, default 7, bank depth DEPTH = 2^ADDR_W frames.
REQ-003 Parameter NUM_CH, default 2, channels per frame (ch0 = left, ch1 = right).
REQ-004 One clock and one reset: clk_ir; reset rst_ih is synchronous and active-high.
REQ-005 clk_ir  in  1  clock; all logic on rising edge.
REQ-006 rst_ih  in  1  synchronous active-high reset.
REQ-007 wr_en_i  in  1  write one frame (all channels) from the producer.
REQ-008 wr_data_i  in  NUM_CH*DATA_W  frame data; ch k occupies bits [k*DATA_W +: DATA_W].
REQ-009 wr_full_o  out  1  current write bank not free; writes are dropped.
REQ-010 ovrflw_o  out  1  sticky flag: a write was dropped.
REQ-011 ovrflw_clr_i  in  1  clears ovrflw_o.
REQ-012 pcm_data_rdy_o  out  1  a full bank is available to the consumer.
REQ-013 pcm_rden_i  in  1  read request.
REQ-014 pcm_addr_i  in  ADDR_W  read frame address within the ready bank.
REQ-015 pcm_rdata_o  out  NUM_CH*DATA_W  read frame, same channel packing as wr_data_i.
REQ-016 pcm_rd_valid_o  out  1  pcm_rdata_o valid this cycle.
REQ-017 pcm_rd_done_i  in  1  consumer releases the ready bank.
REQ-018 rd_bank_o  out  1  index of the bank presented to the consumer.

Function
REQ-019 Storage SHALL be two banks (ping-pong) of DEPTH frames each, each bank in state EMPTY or FULL.
REQ-020 Write registers: wbank (1 bit), waddr (ADDR_W bits); read register: rbank (1 bit).
REQ-021 wr_full_o SHALL equal (state[wbank] == FULL), derived from registers only.
REQ-022 wr_en_i with wr_full_o low SHALL store wr_data_i at (wbank, waddr) and increment waddr.
REQ-023 Write at waddr == DEPTH-1 SHALL set state[wbank]=FULL, toggle wbank, wrap waddr to 0.
REQ-024 wr_en_i with wr_full_o high SHALL be dropped (no storage, no pointer change) and set ovrflw_o next cycle.
REQ-025 ovrflw_o SHALL clear on ovrflw_clr_i; set and clear in the same cycle: set wins.
REQ-026 pcm_data_rdy_o SHALL equal (state[rbank] == FULL); it rises the cycle after the bank-filling write.
REQ-027 pcm_rden_i with pcm_data_rdy_o high SHALL return bank rbank, address pcm_addr_i, on pcm_rdata_o with pcm_rd_valid_o high exactly 1 cycle later.
REQ-028 pcm_rden_i with pcm_data_rdy_o low SHALL be ignored; pcm_rd_valid_o stays low.
REQ-029 pcm_rdata_o SHALL hold its last value when pcm_rd_valid_o is low.
REQ-030 pcm_rd_done_i with pcm_data_rdy_o high SHALL set state[rbank]=EMPTY and toggle rbank; otherwise ignored.
REQ-031 rden and rd_done in the same cycle: the read SHALL be served from the bank being released.
REQ-032 Bank-filling write and rd_done in the same cycle SHALL both take effect (banks are necessarily distinct).
REQ-033 Back-to-back reads SHALL be supported every cycle (throughput 1 frame/cycle each side).
REQ-034 Reads SHALL NOT alter any bank state or pointer.

Reset
REQ-035 On rst_ih: both banks EMPTY, wbank=0, waddr=0, rbank=0.
REQ-036 On rst_ih: wr_full_o=0, ovrflw_o=0, pcm_data_rdy_o=0, pcm_rd_valid_o=0, rd_bank_o=0, pcm_rdata_o=0.
REQ-037 Reset mid-fill or mid-read SHALL discard all buffered frames; a read issued the reset cycle SHALL NOT produce rd_valid.
REQ-038 Memory contents need not be cleared by reset.

Verification
REQ-039 Defaults: write 128 frames ch0=i, ch1=0x8000_0000+i -> pcm_data_rdy_o high next cycle, rd_bank_o=0, wr_full_o=0.
REQ-040 Read addr 0,5,127 back-to-back -> rd_valid on 3 consecutive cycles, data {0x8000_0000,0},{0x8000_0005,5},{0x8000_007F,0x7F}.
REQ-041 Fill both banks (256 frames), write frame 257 -> wr_full_o=1, ovrflw_o=1 next cycle, bank data unchanged; ovrflw_clr_i -> 0.
REQ-042 rd_done with rden addr 3 same cycle while bank 1 completes fill -> data from bank 0 addr 3, rd_bank_o=1, pcm_data_rdy_o stays 1.
REQ-043 rden/rd_done with no ready bank -> no rd_valid, state unchanged.
REQ-044 rst_ih during 60th write of bank 0 with rden pending -> all outputs reset, no rd_valid, next full bank needs 128 fresh writes; repeat with NUM_CH=4, ADDR_W=4.

Source files
------------

// File: rtl/syn_pcm_mcbuf.sv
// Ping-pong PCM frame buffer between a frame producer and a block consumer.
// Two banks of DEPTH frames each. The producer fills one bank at a time.
// A filled bank is handed to the consumer. The consumer reads it at random
// addresses and releases it with pcm_rd_done_i.
module syn_pcm_mcbuf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int NUM_CH = 2
) (
    input  logic                     clk_ir,
    input  logic                     rst_ih,
    input  logic                     wr_en_i,
    input  logic [NUM_CH*DATA_W-1:0] wr_data_i,
    output logic                     wr_full_o,
    output logic                     ovrflw_o,
    input  logic                     ovrflw_clr_i,
    output logic                     pcm_data_rdy_o,
    input  logic                     pcm_rden_i,
    input  logic [ADDR_W-1:0]        pcm_addr_i,
    output logic [NUM_CH*DATA_W-1:0] pcm_rdata_o,
    output logic                     pcm_rd_valid_o,
    input  logic                     pcm_rd_done_i,
    output logic                     rd_bank_o
);

    localparam int FRAME_W = NUM_CH * DATA_W;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic [FRAME_W-1:0] mem [2*DEPTH];

    logic [1:0]         bank_full;
    logic               wbank;
    logic               rbank;
    logic [ADDR_W-1:0]  waddr;
    logic               ovrflw;
    logic               rd_valid;
    logic [FRAME_W-1:0] rdata;

    logic wr_accept;
    logic wr_drop;
    logic rd_accept;
    logic rd_release;

    // Bank status decides every handshake. The flags come straight from
    // registers, so they are stable for the whole cycle.
    assign wr_accept  = wr_en_i && !bank_full[wbank];
    assign wr_drop    = wr_en_i &&  bank_full[wbank];
    assign rd_accept  = pcm_rden_i    && bank_full[rbank];
    assign rd_release = pcm_rd_done_i && bank_full[rbank];

    assign wr_full_o      = bank_full[wbank];
    assign pcm_data_rdy_o = bank_full[rbank];
    assign rd_bank_o      = rbank;
    assign ovrflw_o       = ovrflw;
    assign pcm_rdata_o    = rdata;
    assign pcm_rd_valid_o = rd_valid;

    // Frame storage. Reset leaves the contents alone; it only drops the
    // write issued in the reset cycle.
    always_ff @(posedge clk_ir) begin
        if (!rst_ih && wr_accept)
            mem[{wbank, waddr}] <= wr_data_i;
    end

    // Bank ownership, write pointer and overflow flag.
    // A bank-filling write and a release never touch the same bank: the
    // write bank is EMPTY and the released bank is FULL. Both per-bit
    // updates can therefore land in the same cycle.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            bank_full <= 2'b00;
            wbank     <= 1'b0;
            waddr     <= '0;
            rbank     <= 1'b0;
            ovrflw    <= 1'b0;
        end else begin
            if (wr_accept) begin
                waddr <= waddr + 1'b1;
                if (waddr == ADDR_W'(DEPTH - 1)) begin
                    bank_full[wbank] <= 1'b1;
                    wbank            <= ~wbank;
                end
            end
            if (rd_release) begin
                bank_full[rbank] <= 1'b0;
                rbank            <= ~rbank;
            end
            if (wr_drop)
                ovrflw <= 1'b1;
            else if (ovrflw_clr_i)
                ovrflw <= 1'b0;
        end
    end

    // Registered read port. It samples the current rbank before any release
    // in the same cycle takes effect. When no read is accepted, rdata holds
    // its last value.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            rd_valid <= 1'b0;
            rdata    <= '0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept)
                rdata <= mem[{rbank, pcm_addr_i}];
        end
    end

endmodule

// File: tb/tb_syn_pcm_mcbuf.sv
// Scoreboard bench for syn_pcm_mcbuf.
// Instance A uses the default geometry. Instance B uses 4 channels x 16 bits
// with 16-frame banks.
module tb_syn_pcm_mcbuf;

    logic clk_ir = 1'b0;
    always #5 clk_ir = ~clk_ir;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance A (defaults) ----------------
    logic        a_rst = 1'b1, a_wr_en = 1'b0, a_clr = 1'b0, a_rden = 1'b0, a_done = 1'b0;
    logic [63:0] a_wr_data = '0;
    logic [6:0]  a_addr = '0;
    logic        a_wr_full, a_ovrflw, a_rdy, a_rd_valid, a_rd_bank;
    logic [63:0] a_rdata;

    syn_pcm_mcbuf u_a (
        .clk_ir(clk_ir), .rst_ih(a_rst),
        .wr_en_i(a_wr_en), .wr_data_i(a_wr_data), .wr_full_o(a_wr_full),
        .ovrflw_o(a_ovrflw), .ovrflw_clr_i(a_clr),
        .pcm_data_rdy_o(a_rdy), .pcm_rden_i(a_rden), .pcm_addr_i(a_addr),
        .pcm_rdata_o(a_rdata), .pcm_rd_valid_o(a_rd_valid),
        .pcm_rd_done_i(a_done), .rd_bank_o(a_rd_bank)
    );

    // ---------------- instance B (NUM_CH=4, ADDR_W=4) ----------------
    logic        b_rst = 1'b1, b_wr_en = 1'b0, b_clr = 1'b0, b_rden = 1'b0, b_done = 1'b0;
    logic [63:0] b_wr_data = '0;
    logic [3:0]  b_addr = '0;
    logic        b_wr_full, b_ovrflw, b_rdy, b_rd_valid, b_rd_bank;
    logic [63:0] b_rdata;

    syn_pcm_mcbuf #(.DATA_W(16), .ADDR_W(4), .NUM_CH(4)) u_b (
        .clk_ir(clk_ir), .rst_ih(b_rst),
        .wr_en_i(b_wr_en), .wr_data_i(b_wr_data), .wr_full_o(b_wr_full),
        .ovrflw_o(b_ovrflw), .ovrflw_clr_i(b_clr),
        .pcm_data_rdy_o(b_rdy), .pcm_rden_i(b_rden), .pcm_addr_i(b_addr),
        .pcm_rdata_o(b_rdata), .pcm_rd_valid_o(b_rd_valid),
        .pcm_rd_done_i(b_done), .rd_bank_o(b_rd_bank)
    );

    logic [63:0] qa[$];
    logic [63:0] qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ch0 in the low half, ch1 in the high half
    function automatic logic [63:0] fa(input int i);
        return {32'h8000_0000 + 32'(i), 32'(i)};
    endfunction

    // four 16-bit channels, ch k = 0x(k+1)000 + i
    function automatic logic [63:0] fb(input int i);
        return {16'(32'h4000 + i), 16'(32'h3000 + i), 16'(32'h2000 + i), 16'(32'h1000 + i)};
    endfunction

    // Each monitor pops the next expected frame for every valid read.
    always @(negedge clk_ir) begin
        if (a_rd_valid === 1'b1) begin
            if (qa.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a_unexpected_valid: got rdata %0h, expected no valid", a_rdata);
            end else begin
                chk("a_rdata", a_rdata, qa.pop_front());
            end
        end
    end

    always @(negedge clk_ir) begin
        if (b_rd_valid === 1'b1) begin
            if (qb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected_valid: got rdata %0h, expected no valid", b_rdata);
            end else begin
                chk("b_rdata", b_rdata, qb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk_ir);
        #1;
    endtask

    task automatic wr_a(input logic [63:0] d);
        a_wr_en = 1'b1; a_wr_data = d;
        step();
        a_wr_en = 1'b0;
    endtask

    task automatic rd_a(input int addr, input logic [63:0] exp);
        a_rden = 1'b1; a_addr = 7'(addr);
        qa.push_back(exp);
        step();
        a_rden = 1'b0;
        chk("a_rd_valid", a_rd_valid, 1'b1);
    endtask

    task automatic wr_b(input logic [63:0] d);
        b_wr_en = 1'b1; b_wr_data = d;
        step();
        b_wr_en = 1'b0;
    endtask

    task automatic rd_b(input int addr, input logic [63:0] exp);
        b_rden = 1'b1; b_addr = 4'(addr);
        qb.push_back(exp);
        step();
        b_rden = 1'b0;
        chk("b_rd_valid", b_rd_valid, 1'b1);
    endtask

    task automatic chk_reset_a();
        chk("a_rst_wr_full", a_wr_full, 1'b0);
        chk("a_rst_ovrflw", a_ovrflw, 1'b0);
        chk("a_rst_rdy", a_rdy, 1'b0);
        chk("a_rst_rd_valid", a_rd_valid, 1'b0);
        chk("a_rst_rd_bank", a_rd_bank, 1'b0);
        chk("a_rst_rdata", a_rdata, 64'h0);
    endtask

    task automatic chk_reset_b();
        chk("b_rst_wr_full", b_wr_full, 1'b0);
        chk("b_rst_ovrflw", b_ovrflw, 1'b0);
        chk("b_rst_rdy", b_rdy, 1'b0);
        chk("b_rst_rd_valid", b_rd_valid, 1'b0);
        chk("b_rst_rd_bank", b_rd_bank, 1'b0);
        chk("b_rst_rdata", b_rdata, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        step(); step();
        a_rst = 1'b0; b_rst = 1'b0;
        chk_reset_a();
        chk_reset_b();

        // release/read with no ready bank: ignored
        a_rden = 1'b1; a_done = 1'b1; a_addr = 7'd3;
        step();
        a_rden = 1'b0; a_done = 1'b0;
        chk("a_idle_rd_valid", a_rd_valid, 1'b0);
        chk("a_idle_rdy", a_rdy, 1'b0);
        chk("a_idle_rd_bank", a_rd_bank, 1'b0);

        // fill bank 0
        for (int i = 0; i < 127; i++) wr_a(fa(i));
        chk("a_rdy_before_last", a_rdy, 1'b0);
        wr_a(fa(127));
        chk("a_fill0_rdy", a_rdy, 1'b1);
        chk("a_fill0_rd_bank", a_rd_bank, 1'b0);
        chk("a_fill0_wr_full", a_wr_full, 1'b0);

        // back-to-back reads
        rd_a(0, fa(0));
        rd_a(5, fa(5));
        rd_a(127, fa(127));
        step();
        chk("a_rd_valid_drop", a_rd_valid, 1'b0);

        // bank 1 completes its fill in the same cycle that bank 0 is released
        // while address 3 is read
        for (int i = 128; i < 255; i++) wr_a(fa(i));
        a_wr_en = 1'b1; a_wr_data = fa(255);
        a_done = 1'b1; a_rden = 1'b1; a_addr = 7'd3;
        qa.push_back(fa(3));
        step();
        a_wr_en = 1'b0; a_done = 1'b0; a_rden = 1'b0;
        chk("a_swap_rd_valid", a_rd_valid, 1'b1);
        chk("a_swap_rd_bank", a_rd_bank, 1'b1);
        chk("a_swap_rdy", a_rdy, 1'b1);
        chk("a_swap_wr_full", a_wr_full, 1'b0);

        // refill bank 0 so that both banks are full, then overflow
        for (int i = 256; i < 384; i++) wr_a(fa(i));
        chk("a_both_wr_full", a_wr_full, 1'b1);
        chk("a_both_ovrflw", a_ovrflw, 1'b0);
        wr_a(64'hDEAD_BEEF_0BAD_F00D);
        chk("a_ovf_set", a_ovrflw, 1'b1);
        chk("a_ovf_wr_full", a_wr_full, 1'b1);
        rd_a(0, fa(128));
        rd_a(127, fa(255));
        a_wr_en = 1'b1; a_clr = 1'b1;
        step();
        a_wr_en = 1'b0;
        chk("a_ovf_set_wins", a_ovrflw, 1'b1);
        step();
        a_clr = 1'b0;
        chk("a_ovf_clr", a_ovrflw, 1'b0);

        // release bank 1; bank 0 must still hold frames 256..383
        a_done = 1'b1;
        step();
        a_done = 1'b0;
        chk("a_rel_rd_bank", a_rd_bank, 1'b0);
        chk("a_rel_rdy", a_rdy, 1'b1);
        chk("a_rel_wr_full", a_wr_full, 1'b0);
        rd_a(0, fa(256));

        // reset on the 60th write of a bank while a read is requested
        for (int i = 0; i < 59; i++) wr_a(fa(32'h300 + i));
        a_wr_en = 1'b1; a_wr_data = fa(32'h300 + 59);
        a_rst = 1'b1; a_rden = 1'b1; a_addr = 7'd0;
        step();
        a_wr_en = 1'b0; a_rst = 1'b0; a_rden = 1'b0;
        chk_reset_a();
        for (int i = 0; i < 127; i++) wr_a(fa(32'h200 + i));
        chk("a_fresh_rdy_early", a_rdy, 1'b0);
        wr_a(fa(32'h200 + 127));
        chk("a_fresh_rdy", a_rdy, 1'b1);
        chk("a_fresh_rd_bank", a_rd_bank, 1'b0);
        rd_a(0, fa(32'h200));
        rd_a(127, fa(32'h27F));

        // instance B: 4-channel packing and mid-fill reset
        for (int i = 0; i < 16; i++) wr_b(fb(i));
        chk("b_fill0_rdy", b_rdy, 1'b1);
        rd_b(2, fb(2));
        for (int i = 16; i < 25; i++) wr_b(fb(i));
        b_wr_en = 1'b1; b_wr_data = fb(25);
        b_rst = 1'b1; b_rden = 1'b1; b_addr = 4'd5;
        step();
        b_wr_en = 1'b0; b_rst = 1'b0; b_rden = 1'b0;
        chk_reset_b();
        for (int i = 0; i < 15; i++) wr_b(fb(32'h80 + i));
        chk("b_fresh_rdy_early", b_rdy, 1'b0);
        wr_b(fb(32'h80 + 15));
        chk("b_fresh_rdy", b_rdy, 1'b1);
        chk("b_fresh_rd_bank", b_rd_bank, 1'b0);
        rd_b(0, fb(32'h80));
        rd_b(15, fb(32'h8F));

        step(); step();
        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("b_queue_drained", 64'(qb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
